// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - dual SPI ADC channel-scan sequencer with DSP-bus result window
//
// Purpose: on a rising SOC edge, runs NUM_CH+1 SPI frames to both ADCs in lock-step.
// The results of every channel are kept in two banks, RES1 and RES2, which the DSP
// external bus can read.
//
// Ports:
//   CLK, RESET        system clock, synchronous active-high reset
//   SOC               start-of-conversion request (asynchronous, rising edge)
//   BUSY, EOC         scan running / one-cycle scan-complete pulse
//   SCLK, CS1n, CS2n  SPI clock (idles high) and per-ADC chip selects
//   MOSI              shared command line, MSB first
//   MISO1, MISO2      per-ADC data returns
//   Addr, CSn, OEn    DSP bus read request
//   RD_DATA, RD_HIT   registered read data and window-hit flag
module adc_scan_sequencer #(
    parameter int          CLK_DIV   = 10,
    parameter int          NUM_CH    = 8,
    parameter logic [13:0] BASE_ADDR = 14'h0100,
    parameter logic [10:0] CTRL_LSB  = 11'h310
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SOC,
    output logic        BUSY,
    output logic        EOC,
    output logic        SCLK,
    output logic        CS1n,
    output logic        CS2n,
    output logic        MOSI,
    input  logic        MISO1,
    input  logic        MISO2,
    input  logic [13:0] Addr,
    input  logic        CSn,
    input  logic        OEn,
    output logic [15:0] RD_DATA,
    output logic        RD_HIT
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_QUIET,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [4:0]         half_q, half_d;
    logic [3:0]         frame_q, frame_d;
    logic [15:0]        shift1_q, shift1_d;
    logic [15:0]        shift2_q, shift2_d;
    logic [15:0]        res1_q [0:7];
    logic [15:0]        res1_d [0:7];
    logic [15:0]        res2_q [0:7];
    logic [15:0]        res2_d [0:7];
    logic [7:0]         scan_cnt_q, scan_cnt_d;
    logic               overrun_q, overrun_d;
    logic               soc_meta_q, soc_meta_d;
    logic               soc_sync_q, soc_sync_d;
    logic               soc_prev_q, soc_prev_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic               rd_hit_q, rd_hit_d;
    logic               rd_status_q, rd_status_d;

    logic               soc_edge;
    logic               busy;
    logic               div_last;
    logic               sclk_rise;
    logic [2:0]         cmd_ch;
    logic [15:0]        cmd_word;
    logic [3:0]         cmd_bit;
    logic [13:0]        rd_off;

    assign soc_edge = soc_sync_q & ~soc_prev_q;
    assign busy     = (state_q != S_IDLE);

    // QUIET is the only phase that lasts two half-periods; every other phase
    // boundary (including each SCLK half-period in SHIFT) is CLK_DIV cycles.
    always_comb begin
        if (state_q == S_QUIET) begin
            div_last = (div_cnt_q == DIV_W'(2 * CLK_DIV - 1));
        end else begin
            div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        end
    end

    // SCLK is low during even half-periods of SHIFT, so it rises on the first
    // cycle of each odd half-period; that is when the ADC data bit is captured.
    assign sclk_rise = (state_q == S_SHIFT) && half_q[0] && (div_cnt_q == '0);

    // The final frame re-addresses channel 0 only to clock out the last result.
    assign cmd_ch   = (frame_q < 4'(NUM_CH)) ? frame_q[2:0] : 3'd0;
    assign cmd_word = {1'b1, 1'b0, cmd_ch, CTRL_LSB};
    assign cmd_bit  = 4'd15 - half_q[4:1];

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (soc_edge) state_d = S_SETUP;
            S_SETUP: if (div_last) state_d = S_SHIFT;
            S_SHIFT: if (div_last && (half_q == 5'd31)) state_d = S_HOLD;
            S_HOLD:  if (div_last) state_d = S_QUIET;
            S_QUIET: if (div_last) state_d = (frame_q == 4'(NUM_CH)) ? S_DONE : S_SETUP;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = busy;
        EOC  = (state_q == S_DONE);
        CS1n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        case (state_q)
            S_SETUP: begin
                CS1n = 1'b0;
                MOSI = cmd_word[15];
            end
            S_SHIFT: begin
                CS1n = 1'b0;
                SCLK = half_q[0];
                MOSI = cmd_word[cmd_bit];
            end
            S_HOLD:  CS1n = 1'b0;
            default: ;
        endcase
        CS2n = CS1n;
    end

    // Datapath next-state
    always_comb begin
        soc_meta_d = SOC;
        soc_sync_d = soc_meta_q;
        soc_prev_d = soc_sync_q;

        div_cnt_d  = div_cnt_q + DIV_W'(1);
        if ((state_q == S_IDLE) || (state_q == S_DONE) || div_last) begin
            div_cnt_d = '0;
        end

        half_d = half_q;
        if (state_q != S_SHIFT) begin
            half_d = 5'd0;
        end else if (div_last) begin
            half_d = half_q + 5'd1;
        end

        frame_d = frame_q;
        if (state_q == S_IDLE) begin
            frame_d = 4'd0;
        end else if ((state_q == S_QUIET) && div_last) begin
            frame_d = frame_q + 4'd1;
        end

        shift1_d = shift1_q;
        shift2_d = shift2_q;
        if (sclk_rise) begin
            shift1_d = {shift1_q[14:0], MISO1};
            shift2_d = {shift2_q[14:0], MISO2};
        end

        // Frame k carries the result addressed in frame k-1, so frame 0 is dropped.
        res1_d = res1_q;
        res2_d = res2_q;
        if ((state_q == S_SHIFT) && (state_d == S_HOLD) && (frame_q != 4'd0)) begin
            res1_d[3'(frame_q - 4'd1)] = shift1_q;
            res2_d[3'(frame_q - 4'd1)] = shift2_q;
        end

        scan_cnt_d = scan_cnt_q;
        if (state_q == S_DONE) begin
            scan_cnt_d = scan_cnt_q + 8'd1;
        end

        // A new overrun edge takes priority over the clear from a status read.
        overrun_d = overrun_q;
        if (rd_status_q) begin
            overrun_d = 1'b0;
        end
        if (soc_edge && busy) begin
            overrun_d = 1'b1;
        end
    end

    // Bus read decode; offsets wrap in 14 bits so addresses below BASE_ADDR miss.
    assign rd_off = Addr - BASE_ADDR;

    always_comb begin
        rd_hit_d    = 1'b0;
        rd_data_d   = 16'h0000;
        rd_status_d = 1'b0;
        if (!CSn && !OEn) begin
            if (rd_off < 14'(NUM_CH)) begin
                rd_hit_d  = 1'b1;
                rd_data_d = res1_q[rd_off[2:0]];
            end else if ((rd_off >= 14'd8) && (rd_off < 14'(8 + NUM_CH))) begin
                rd_hit_d  = 1'b1;
                rd_data_d = res2_q[rd_off[2:0]];
            end else if (rd_off == 14'd16) begin
                rd_hit_d    = 1'b1;
                rd_status_d = 1'b1;
                rd_data_d   = {scan_cnt_q, 6'b000000, overrun_q, busy};
            end
        end
    end

    assign RD_DATA = rd_data_q;
    assign RD_HIT  = rd_hit_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt_q   <= '0;
            half_q      <= 5'd0;
            frame_q     <= 4'd0;
            shift1_q    <= 16'h0000;
            shift2_q    <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                res1_q[i] <= 16'h0000;
                res2_q[i] <= 16'h0000;
            end
            scan_cnt_q  <= 8'd0;
            overrun_q   <= 1'b0;
            soc_meta_q  <= 1'b0;
            soc_sync_q  <= 1'b0;
            soc_prev_q  <= 1'b0;
            rd_data_q   <= 16'h0000;
            rd_hit_q    <= 1'b0;
            rd_status_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            half_q      <= half_d;
            frame_q     <= frame_d;
            shift1_q    <= shift1_d;
            shift2_q    <= shift2_d;
            res1_q      <= res1_d;
            res2_q      <= res2_d;
            scan_cnt_q  <= scan_cnt_d;
            overrun_q   <= overrun_d;
            soc_meta_q  <= soc_meta_d;
            soc_sync_q  <= soc_sync_d;
            soc_prev_q  <= soc_prev_d;
            rd_data_q   <= rd_data_d;
            rd_hit_q    <= rd_hit_d;
            rd_status_q <= rd_status_d;
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - scoreboard bench for adc_scan_sequencer
module tb_adc_scan_sequencer;

    localparam logic [13:0] BASE = 14'h0100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SOC;
    logic        BUSY, EOC, SCLK, CS1n, CS2n, MOSI;
    logic        MISO1 = 1'b0;
    logic        MISO2 = 1'b0;
    logic [13:0] Addr;
    logic        CSn, OEn;
    logic [15:0] RD_DATA;
    logic        RD_HIT;

    always #5 CLK = ~CLK;

    adc_scan_sequencer dut (
        .CLK(CLK), .RESET(RESET), .SOC(SOC), .BUSY(BUSY), .EOC(EOC),
        .SCLK(SCLK), .CS1n(CS1n), .CS2n(CS2n), .MOSI(MOSI),
        .MISO1(MISO1), .MISO2(MISO2), .Addr(Addr), .CSn(CSn), .OEn(OEn),
        .RD_DATA(RD_DATA), .RD_HIT(RD_HIT)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected MOSI words per frame: {1,0,ch,11'h310}, last frame re-addresses ch 0.
    logic [15:0] cmd_tab [0:8] = '{16'h8310, 16'h8B10, 16'h9310, 16'h9B10, 16'hA310,
                                   16'hAB10, 16'hB310, 16'hBB10, 16'h8310};

    typedef struct {
        logic        hit;
        logic [15:0] data;
        string       name;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [15:0] mosi_q[$];
    int          eoc_q[$];

    // Read-response monitor
    logic rd_drive = 1'b0;
    logic rd_samp  = 1'b0;
    always @(posedge CLK) rd_samp <= rd_drive;

    always @(negedge CLK) begin
        rd_exp_t e;
        if (rd_samp) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e = rd_q.pop_front();
                chk({e.name, "_hit"}, {31'd0, RD_HIT}, {31'd0, e.hit});
                chk({e.name, "_data"}, {16'd0, RD_DATA}, {16'd0, e.data});
            end
        end
    end

    // ADC models plus SPI / scan-completion monitor
    logic [15:0] p1 = 16'hA000;
    logic [15:0] p2 = 16'h5000;
    logic [15:0] w1, w2, cmd_rx;
    logic [2:0]  prev_ch = 3'd0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, prev_busy = 1'b0;
    logic        quiet_valid = 1'b0, bad_period, bad_stable, cs_diff;
    int          cyc = 0, idx, nrise, nfall;
    int          t_csfall, t_csrise, t_firstfall, t_lastrise, scan_t0;
    int          eoc_cnt = 0, frames_seen = 0;

    always @(negedge CLK) begin
        cyc++;
        if (RESET) begin
            prev_cs = 1'b1; prev_sclk = 1'b1; prev_busy = 1'b0;
            quiet_valid = 1'b0; prev_ch = 3'd0;
            MISO1 = 1'b0; MISO2 = 1'b0;
        end else begin
            if (BUSY && !prev_busy) begin
                scan_t0 = cyc;
                frames_seen = 0;
            end
            if (EOC) begin
                eoc_cnt++;
                quiet_valid = 1'b0;
                if (eoc_q.size() == 0) chk("eoc_unexpected", 1, 0);
                else chk("scan_len", cyc - scan_t0 + 1, eoc_q.pop_front());
            end
            if (prev_cs && !CS1n) begin
                frames_seen++;
                if (quiet_valid) chk("quiet_len", cyc - t_csrise, 20);
                t_csfall = cyc;
                w1 = p1 | {13'd0, prev_ch};
                w2 = p2 | {13'd0, prev_ch};
                idx = 15;
                MISO1 = w1[15]; MISO2 = w2[15];
                nrise = 0; nfall = 0; cmd_rx = 16'h0;
                bad_period = 1'b0; bad_stable = 1'b0; cs_diff = 1'b0;
            end
            if (CS1n !== CS2n) cs_diff = 1'b1;
            if (!CS1n) begin
                if (prev_sclk && !SCLK) begin
                    nfall++;
                    if (nfall == 1) begin
                        t_firstfall = cyc;
                    end else if (idx > 0) begin
                        idx--;
                        MISO1 = w1[idx]; MISO2 = w2[idx];
                    end
                end
                if (!prev_sclk && SCLK) begin
                    nrise++;
                    if (nrise > 1 && (cyc - t_lastrise) != 20) bad_period = 1'b1;
                    t_lastrise = cyc;
                    cmd_rx = {cmd_rx[14:0], MOSI};
                    if (MOSI !== prev_mosi) bad_stable = 1'b1;
                end
            end
            if (!prev_cs && CS1n) begin
                chk("sclk_rises", nrise, 16);
                chk("cs_setup", t_firstfall - t_csfall, 10);
                chk("last_rise_to_cs", cyc - t_lastrise, 20);
                chk("sclk_period_bad", {31'd0, bad_period}, 0);
                chk("mosi_unstable", {31'd0, bad_stable}, 0);
                chk("cs1_cs2_differ", {31'd0, cs_diff}, 0);
                if (mosi_q.size() == 0) chk("mosi_unexpected", 1, 0);
                else chk("mosi_word", {16'd0, cmd_rx}, {16'd0, mosi_q.pop_front()});
                prev_ch = cmd_rx[13:11];
                t_csrise = cyc;
                quiet_valid = 1'b1;
            end
            prev_cs = CS1n; prev_sclk = SCLK; prev_mosi = MOSI; prev_busy = BUSY;
        end
    end

    task automatic do_read(input logic [13:0] a, input logic csn, input logic oen,
                           input logic hit, input logic [15:0] d, input string name);
        rd_exp_t e;
        @(negedge CLK);
        Addr = a; CSn = csn; OEn = oen; rd_drive = 1'b1;
        e.hit = hit; e.data = d; e.name = name;
        rd_q.push_back(e);
        @(negedge CLK);
        CSn = 1'b1; OEn = 1'b1; rd_drive = 1'b0;
    endtask

    task automatic start_scan(input logic [15:0] a1, input logic [15:0] a2);
        @(negedge CLK);
        p1 = a1; p2 = a2;
        for (int k = 0; k < 9; k++) mosi_q.push_back(cmd_tab[k]);
        eoc_q.push_back(3241);
        SOC = 1'b1;
        repeat (2) @(negedge CLK);
        chk("busy_before_sync", {31'd0, BUSY}, 0);
        @(negedge CLK);
        chk("busy_rise_3clk", {31'd0, BUSY}, 1);
        chk("cs_fall_with_busy", {31'd0, CS1n}, 0);
        repeat (3) @(negedge CLK);
        SOC = 1'b0;
    endtask

    task automatic wait_eoc(input int budget);
        int s = eoc_cnt;
        int n = 0;
        while (eoc_cnt == s && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("eoc_timeout", {31'd0, eoc_cnt != s}, 1);
    endtask

    task automatic read_banks(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] st);
        for (int i = 0; i < 8; i++) begin
            do_read(BASE + 14'(i), 1'b0, 1'b0, 1'b1, a1 | 16'(i), $sformatf("res1_%0d", i));
            do_read(BASE + 14'(8 + i), 1'b0, 1'b0, 1'b1, a2 | 16'(i), $sformatf("res2_%0d", i));
        end
        do_read(BASE + 14'd16, 1'b0, 1'b0, 1'b1, st, "status");
    endtask

    initial begin
        int n;
        RESET = 1'b1; SOC = 1'b0; CSn = 1'b1; OEn = 1'b1; Addr = 14'h0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_eoc", {31'd0, EOC}, 0);
        chk("rst_sclk", {31'd0, SCLK}, 1);
        chk("rst_cs1n", {31'd0, CS1n}, 1);
        chk("rst_cs2n", {31'd0, CS2n}, 1);
        chk("rst_mosi", {31'd0, MOSI}, 0);
        chk("rst_rd_data", {16'd0, RD_DATA}, 0);
        chk("rst_rd_hit", {31'd0, RD_HIT}, 0);
        do_read(BASE + 14'd0, 1'b0, 1'b0, 1'b1, 16'h0000, "rst_off0");
        do_read(BASE + 14'd8, 1'b0, 1'b0, 1'b1, 16'h0000, "rst_off8");
        do_read(BASE + 14'd16, 1'b0, 1'b0, 1'b1, 16'h0000, "rst_off16");

        // Single scan with default-pattern ADCs
        start_scan(16'hA000, 16'h5000);
        wait_eoc(4000);
        read_banks(16'hA000, 16'h5000, 16'h0100);

        // Overrun: second SOC edge mid-scan
        start_scan(16'hA000, 16'h5000);
        repeat (500) @(negedge CLK);
        SOC = 1'b1;
        repeat (4) @(negedge CLK);
        SOC = 1'b0;
        wait_eoc(4000);
        repeat (100) @(negedge CLK);
        chk("no_second_scan", {31'd0, BUSY}, 0);
        do_read(BASE + 14'd16, 1'b0, 1'b0, 1'b1, 16'h0202, "status_overrun");
        do_read(BASE + 14'd16, 1'b0, 1'b0, 1'b1, 16'h0200, "status_cleared");

        // Reset during frame 4
        start_scan(16'hA000, 16'h5000);
        n = 0;
        while (frames_seen < 5 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk("frame4_timeout", {31'd0, frames_seen >= 5}, 1);
        repeat (30) @(negedge CLK);
        RESET = 1'b1;
        mosi_q.delete();
        eoc_q.delete();
        @(negedge CLK);
        chk("midrst_cs1n", {31'd0, CS1n}, 1);
        chk("midrst_cs2n", {31'd0, CS2n}, 1);
        chk("midrst_sclk", {31'd0, SCLK}, 1);
        chk("midrst_busy", {31'd0, BUSY}, 0);
        chk("midrst_mosi", {31'd0, MOSI}, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++)
            do_read(BASE + 14'(i), 1'b0, 1'b0, 1'b1, 16'h0000, $sformatf("midrst_res1_%0d", i));
        do_read(BASE + 14'd16, 1'b0, 1'b0, 1'b1, 16'h0000, "midrst_status");

        // Fresh scan with a different data pattern
        start_scan(16'h3C00, 16'hC300);
        wait_eoc(4000);
        read_banks(16'h3C00, 16'hC300, 16'h0100);

        // Window decode boundaries
        do_read(BASE + 14'd7, 1'b0, 1'b0, 1'b1, 16'h3C07, "win_res1_last");
        do_read(BASE + 14'd15, 1'b0, 1'b0, 1'b1, 16'hC307, "win_res2_last");
        do_read(BASE + 14'd17, 1'b0, 1'b0, 1'b0, 16'h0000, "win_off17");
        do_read(BASE + 14'd0, 1'b0, 1'b1, 1'b0, 16'h0000, "win_oen_high");
        do_read(BASE + 14'd0, 1'b1, 1'b0, 1'b0, 16'h0000, "win_csn_high");
        do_read(BASE - 14'd1, 1'b0, 1'b0, 1'b0, 16'h0000, "win_below_base");

        repeat (4) @(negedge CLK);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("mosi_queue_drained", mosi_q.size(), 0);
        chk("eoc_queue_drained", eoc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
